booth_mac_accumulator: RTL and testbench
========================================

Name: booth_mac_accumulator

Overview:
- Downstream consumer of the Booth multiplier's product stream; signed multiply-accumulate back end.
- Sums N_TERMS consecutive signed products into a wider accumulator, then presents the frame result with a one-cycle done pulse.
- Accepts the multiplier's level-held valid and 8-bit signed product directly; no glue logic.

Parameters:
- PROD_W, 8, width of the signed product input.
- ACC_W, 12, width of the signed accumulator and result (ACC_W > PROD_W).
- N_TERMS, 4, products per frame (2..255).
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- clear  input  1  synchronous frame abort: zero acc and count.
- mul_valid  input  1  multiplier valid, level, held until its next start.
- mul_z  input  PROD_W  signed product, stable while mul_valid high.
- acc_out  output  ACC_W  signed running/final sum.
- term_cnt  output  8  products accepted in the current frame.
- done  output  1  one-cycle pulse when frame completes.
- overflow  output  1  sticky, set on any saturation/wrap event in the frame.

Behaviour:
- Reset (rst=0 at clk edge): acc_out=0, term_cnt=0, done=0, overflow=0, state=ACCUM, valid_q=1. valid_q=1 suppresses a false accept if mul_valid is already high at reset release.
- Accept condition: accept = mul_valid & ~valid_q, a rising edge of mul_valid. valid_q <= mul_valid every cycle.
- A level held high never double-counts. Each multiplier result is accepted exactly once.
- Latency: acc_out and term_cnt update on the clock edge after the accept cycle (1 cycle).
- Arithmetic: sum = acc + sign_extend(mul_z) in ACC_W+1 bits.
- Overflow detection: sum outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- On overflow with SATURATE=1: clamp to the nearest bound. With SATURATE=0: keep the low ACC_W bits. Either way set overflow=1 (sticky until the next frame start, clear, or reset).
- FSM, 2 states:
  - ACCUM: on accept, acc<=sum and term_cnt++. If term_cnt==N_TERMS-1 on accept: done<=1, go to HOLD.
  - HOLD: acc_out holds the final sum and term_cnt==N_TERMS. done is 1 only on the entry cycle, 0 thereafter.
  - HOLD, on accept: start a new frame. acc<=sign_extend(mul_z), term_cnt<=1, overflow<=0, go to ACCUM.
  - HOLD with N_TERMS==1 is not supported (min 2).
- clear=1: acc=0, term_cnt=0, overflow=0, done=0, state=ACCUM.
- clear and accept in the same cycle: clear wins and the product is discarded. valid_q still updates.
- rst mid-frame: all state returns to reset values. A partial sum is lost.
- done and clear are never both effective: clear forces done=0.

Decomposition:
- Shared package mac_pkg:
  - state enum {ACCUM, HOLD};
  - constant TERM_CNT_W=8;
  - function sat_add(acc, prod) returning the ACC_W result plus an overflow flag.
- One sub-module: rise_detect, a 1-bit rising-edge detector with parameter RESET_VAL (1 here). It is reusable on the multiplier's own start input.

Test Plan:
- Basic frame: reset 2 cycles, then products 35, -24, 49, -64 (each valid rising edge ≥2 cycles apart, held high 3 cycles) -> acc_out 35, 11, 60, -4. term_cnt 1..4. done pulses once, with acc_out=-4 and overflow=0.
- Level-held valid: mul_valid held high 10 cycles with mul_z=35 -> term_cnt=1 and acc_out=35, exactly one accept.
- Reset release with valid high: mul_valid=1 while rst goes 0->1 -> no accept, acc_out=0. The next 0->1 edge with mul_z=-8 gives acc_out=-8.
- Saturation (ACC_W=8, SATURATE=1): products 64, 64, 64, -8 -> acc_out 64, 127, 127, 119. overflow=1 from the second product on. done with 119.
- Wrap (ACC_W=8, SATURATE=0): 64, 64 -> acc_out 64, -128, overflow=1. Then clear -> acc_out=0, term_cnt=0, overflow=0.
- Clear collision and new frame: clear asserted in the same cycle as the accept of mul_z=20 -> acc_out=0, term_cnt=0.
  - Continue: after a full frame (HOLD, acc=-4), the next accept with mul_z=7 -> acc_out=7, term_cnt=1, overflow=0.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and arithmetic helper for the Booth multiply-accumulate
// back end.
//   mac_state_t  : frame FSM state (ACCUM while summing, HOLD once complete)
//   TERM_CNT_W   : width of the per-frame product counter
//   CALC_W       : working width used by sat_add; accumulators up to 31 bits
//   sat_add()    : signed add with saturate-or-wrap and an overflow flag
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_t;

  localparam int TERM_CNT_W = 8;
  localparam int CALC_W     = 32;

  typedef struct packed {
    logic signed [CALC_W-1:0] value;
    logic                     ovf;
  } sat_result_t;

  // Adds two sign-extended operands in one extra bit so that the true sum is
  // always representable, then checks it against the range of an acc_w-bit
  // signed number. In wrap mode the low acc_w bits of value are the
  // two's-complement result; in saturate mode value is the nearest bound.
  function automatic sat_result_t sat_add(
    input logic signed [CALC_W-1:0] acc,
    input logic signed [CALC_W-1:0] prod,
    input int                       acc_w,
    input logic                     saturate
  );
    logic signed [CALC_W:0] sum;
    logic signed [CALC_W:0] max_v;
    logic signed [CALC_W:0] min_v;
    sat_result_t            r;
    sum   = {acc[CALC_W-1], acc} + {prod[CALC_W-1], prod};
    max_v = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (acc_w - 1));
    r.ovf   = 1'b0;
    r.value = sum[CALC_W-1:0];
    if (sum > max_v) begin
      r.ovf = 1'b1;
      if (saturate) r.value = max_v[CALC_W-1:0];
    end else if (sum < min_v) begin
      r.ovf = 1'b1;
      if (saturate) r.value = min_v[CALC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: single-bit rising-edge detector.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   d         : level input
//   rise      : high in the cycle where d is 1 and was 0 at the previous edge
// RESET_VAL sets the remembered level after reset; 1 means a level that is
// already high when reset releases is not treated as a new edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember the level seen at the previous edge.
  always_ff @(posedge clk) begin
    if (!rst) d_q <= RESET_VAL;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: sums N_TERMS consecutive signed products from the
// Booth multiplier into a wider accumulator and flags frame completion.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   clear     : synchronous frame abort (zeroes sum, count, overflow)
//   mul_valid : multiplier valid, held high until the multiplier restarts
//   mul_z     : signed product, stable while mul_valid is high
//   acc_out   : signed running sum, final sum while the frame is held
//   term_cnt  : products accepted in the current frame
//   done      : one-cycle pulse on the edge that completes a frame
//   overflow  : sticky flag for any saturation/wrap in the current frame
module booth_mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W   = 8,
  parameter int ACC_W    = 12,
  parameter int N_TERMS  = 4,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  mul_valid,
  input  logic [PROD_W-1:0]     mul_z,
  output logic [ACC_W-1:0]      acc_out,
  output logic [TERM_CNT_W-1:0] term_cnt,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [TERM_CNT_W-1:0] LAST_CNT = TERM_CNT_W'(N_TERMS - 1);

  mac_state_t                state, state_n;
  logic [ACC_W-1:0]          acc_n;
  logic [TERM_CNT_W-1:0]     cnt_n;
  logic                      done_n;
  logic                      ovf_n;
  logic                      accept;
  logic [ACC_W-1:0]          prod_ext;
  logic signed [CALC_W-1:0]  acc_wide;
  logic signed [CALC_W-1:0]  prod_wide;
  sat_result_t               sat_res;

  // The valid line is a level held across many cycles; only its rising edge
  // marks a fresh product. Resetting the history to 1 stops a level that is
  // already high at reset release from being counted.
  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (mul_valid),
    .rise (accept)
  );

  assign prod_ext  = {{(ACC_W - PROD_W){mul_z[PROD_W-1]}}, mul_z};
  assign acc_wide  = {{(CALC_W - ACC_W){acc_out[ACC_W-1]}}, acc_out};
  assign prod_wide = {{(CALC_W - PROD_W){mul_z[PROD_W-1]}}, mul_z};
  assign sat_res   = sat_add(acc_wide, prod_wide, ACC_W, SATURATE != 0);

  // Frame state and all visible outputs are registered together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ACCUM;
      acc_out  <= '0;
      term_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      acc_out  <= acc_n;
      term_cnt <= cnt_n;
      done     <= done_n;
      overflow <= ovf_n;
    end
  end

  // Next-state logic. clear overrides any accept in the same cycle, which
  // also guarantees done is never raised alongside a clear. An accept in
  // HOLD begins the next frame with the product itself as the first term.
  always_comb begin
    state_n = state;
    acc_n   = acc_out;
    cnt_n   = term_cnt;
    done_n  = 1'b0;
    ovf_n   = overflow;
    if (clear) begin
      state_n = ACCUM;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else if (accept) begin
      case (state)
        ACCUM: begin
          acc_n = sat_res.value[ACC_W-1:0];
          cnt_n = term_cnt + TERM_CNT_W'(1);
          if (sat_res.ovf) ovf_n = 1'b1;
          if (term_cnt == LAST_CNT) begin
            done_n  = 1'b1;
            state_n = HOLD;
          end
        end
        HOLD: begin
          acc_n   = prod_ext;
          cnt_n   = TERM_CNT_W'(1);
          ovf_n   = 1'b0;
          state_n = ACCUM;
        end
        default: state_n = ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// tb_booth_mac_accumulator: drives three accumulator instances with one shared
// stimulus stream (12-bit saturating default, 8-bit saturating, 8-bit
// wrapping) and checks them against directed expectations and an
// integer-arithmetic frame model.
module tb_booth_mac_accumulator;

  localparam int N_TERMS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              mul_valid;
  logic signed [7:0] mul_z;

  logic [11:0] acc0;
  logic [7:0]  acc1, acc2;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        done0, done1, done2;
  logic        ovf0, ovf1, ovf2;

  int assertCount = 0;
  int failCount   = 0;

  int accW[3]    = '{12, 8, 8};
  bit satMode[3] = '{1'b1, 1'b1, 1'b0};

  int mAcc[3];
  bit mOvf[3];
  int mCnt;
  bit mDone;
  bit mHold;
  bit mPrev;

  typedef struct {
    bit clr;
    bit vld;
    int z;
    int expAcc;
    int expCnt;
    bit expDone;
    bit expOvf;
  } vec_t;

  vec_t basicVec[17];

  always #5 clk = ~clk;

  booth_mac_accumulator #(.PROD_W(8), .ACC_W(12), .N_TERMS(N_TERMS), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .mul_valid(mul_valid), .mul_z(mul_z),
    .acc_out(acc0), .term_cnt(cnt0), .done(done0), .overflow(ovf0));

  booth_mac_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(N_TERMS), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .mul_valid(mul_valid), .mul_z(mul_z),
    .acc_out(acc1), .term_cnt(cnt1), .done(done1), .overflow(ovf1));

  booth_mac_accumulator #(.PROD_W(8), .ACC_W(8), .N_TERMS(N_TERMS), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .clear(clear), .mul_valid(mul_valid), .mul_z(mul_z),
    .acc_out(acc2), .term_cnt(cnt2), .done(done2), .overflow(ovf2));

  function automatic int dutAcc(input int k);
    case (k)
      0:       return int'($signed(acc0));
      1:       return int'($signed(acc1));
      default: return int'($signed(acc2));
    endcase
  endfunction

  function automatic int dutCnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int dutDone(input int k);
    case (k)
      0:       return int'(done0);
      1:       return int'(done1);
      default: return int'(done2);
    endcase
  endfunction

  function automatic int dutOvf(input int k);
    case (k)
      0:       return int'(ovf0);
      1:       return int'(ovf1);
      default: return int'(ovf2);
    endcase
  endfunction

  // Frame model: a new product is a 0->1 step of the valid level, each product
  // is added to a running integer sum and then clamped or wrapped into range,
  // and a frame is complete once N_TERMS products have been counted.
  function automatic void modelUpdate();
    bit isNew;
    int s;
    int maxV;
    int minV;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        mAcc[k] = 0;
        mOvf[k] = 1'b0;
      end
      mCnt  = 0;
      mDone = 1'b0;
      mHold = 1'b0;
      mPrev = 1'b1;
      return;
    end
    isNew = mul_valid && !mPrev;
    mPrev = mul_valid;
    mDone = 1'b0;
    if (clear) begin
      for (int k = 0; k < 3; k++) begin
        mAcc[k] = 0;
        mOvf[k] = 1'b0;
      end
      mCnt  = 0;
      mHold = 1'b0;
    end else if (isNew) begin
      if (mHold) begin
        for (int k = 0; k < 3; k++) begin
          mAcc[k] = int'(mul_z);
          mOvf[k] = 1'b0;
        end
        mCnt  = 1;
        mHold = 1'b0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          maxV = (1 << (accW[k] - 1)) - 1;
          minV = -(1 << (accW[k] - 1));
          s = mAcc[k] + int'(mul_z);
          if (s > maxV) begin
            mOvf[k] = 1'b1;
            s = satMode[k] ? maxV : s - (1 << accW[k]);
          end else if (s < minV) begin
            mOvf[k] = 1'b1;
            s = satMode[k] ? minV : s + (1 << accW[k]);
          end
          mAcc[k] = s;
        end
        mCnt = mCnt + 1;
        if (mCnt == N_TERMS) begin
          mDone = 1'b1;
          mHold = 1'b1;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    assertCount++;
    if (got != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic checkModel();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("model acc[%0d]", k), dutAcc(k), mAcc[k]);
      checkOutput($sformatf("model cnt[%0d]", k), dutCnt(k), mCnt);
      checkOutput($sformatf("model done[%0d]", k), dutDone(k), int'(mDone));
      checkOutput($sformatf("model ovf[%0d]", k), dutOvf(k), int'(mOvf[k]));
    end
  endtask

  // One clock: the model sees the same inputs as the DUTs at the edge, and
  // outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input bit c, input bit v, input int z);
    clear     = c;
    mul_valid = v;
    mul_z     = 8'(z);
    tick();
  endtask

  task automatic sendProduct(input int z);
    applyStimulus(1'b0, 1'b1, z);
    applyStimulus(1'b0, 1'b1, z);
    applyStimulus(1'b0, 1'b0, z);
  endtask

  int satIn[4]  = '{64, 64, 64, -8};
  int satAcc[4] = '{64, 127, 127, 119};
  int satOvf[4] = '{0, 1, 1, 1};
  int frameIn[4] = '{35, -24, 49, -64};

  initial begin
    bit nextValid;
    int r;

    basicVec[0]  = '{0, 0,   0,   0, 0, 0, 0};
    basicVec[1]  = '{0, 1,  35,  35, 1, 0, 0};
    basicVec[2]  = '{0, 1,  35,  35, 1, 0, 0};
    basicVec[3]  = '{0, 1,  35,  35, 1, 0, 0};
    basicVec[4]  = '{0, 0,  35,  35, 1, 0, 0};
    basicVec[5]  = '{0, 1, -24,  11, 2, 0, 0};
    basicVec[6]  = '{0, 1, -24,  11, 2, 0, 0};
    basicVec[7]  = '{0, 1, -24,  11, 2, 0, 0};
    basicVec[8]  = '{0, 0, -24,  11, 2, 0, 0};
    basicVec[9]  = '{0, 1,  49,  60, 3, 0, 0};
    basicVec[10] = '{0, 1,  49,  60, 3, 0, 0};
    basicVec[11] = '{0, 1,  49,  60, 3, 0, 0};
    basicVec[12] = '{0, 0,  49,  60, 3, 0, 0};
    basicVec[13] = '{0, 1, -64,  -4, 4, 1, 0};
    basicVec[14] = '{0, 1, -64,  -4, 4, 0, 0};
    basicVec[15] = '{0, 1, -64,  -4, 4, 0, 0};
    basicVec[16] = '{0, 0, -64,  -4, 4, 0, 0};

    rst       = 1'b0;
    clear     = 1'b0;
    mul_valid = 1'b0;
    mul_z     = '0;
    tick();
    tick();
    checkOutput("reset acc", dutAcc(0), 0);
    checkOutput("reset cnt", dutCnt(0), 0);
    checkOutput("reset done", dutDone(0), 0);
    checkOutput("reset ovf", dutOvf(0), 0);
    rst = 1'b1;

    $display("[TB] basic frame");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(basicVec[i].clr, basicVec[i].vld, basicVec[i].z);
      checkOutput($sformatf("basic acc row %0d", i), dutAcc(0), basicVec[i].expAcc);
      checkOutput($sformatf("basic cnt row %0d", i), dutCnt(0), basicVec[i].expCnt);
      checkOutput($sformatf("basic done row %0d", i), dutDone(0), int'(basicVec[i].expDone));
      checkOutput($sformatf("basic ovf row %0d", i), dutOvf(0), int'(basicVec[i].expOvf));
    end

    $display("[TB] clear colliding with accept");
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("collide acc", dutAcc(0), 0);
    checkOutput("collide cnt", dutCnt(0), 0);
    checkOutput("collide done", dutDone(0), 0);
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("collide held acc", dutAcc(0), 0);
    checkOutput("collide held cnt", dutCnt(0), 0);
    applyStimulus(1'b0, 1'b0, 20);

    $display("[TB] frame then restart from hold");
    for (int i = 0; i < 4; i++) sendProduct(frameIn[i]);
    checkOutput("hold acc", dutAcc(0), -4);
    checkOutput("hold cnt", dutCnt(0), 4);
    applyStimulus(1'b0, 1'b1, 7);
    checkOutput("restart acc", dutAcc(0), 7);
    checkOutput("restart cnt", dutCnt(0), 1);
    checkOutput("restart ovf", dutOvf(0), 0);
    checkOutput("restart done", dutDone(0), 0);
    applyStimulus(1'b0, 1'b0, 7);

    $display("[TB] level-held valid");
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 35);
      checkOutput($sformatf("held acc %0d", i), dutAcc(0), 35);
      checkOutput($sformatf("held cnt %0d", i), dutCnt(0), 1);
    end
    applyStimulus(1'b0, 1'b0, 35);

    $display("[TB] reset release with valid high");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, -8);
    checkOutput("in reset acc", dutAcc(0), 0);
    checkOutput("in reset cnt", dutCnt(0), 0);
    applyStimulus(1'b0, 1'b1, -8);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, -8);
      checkOutput($sformatf("release acc %0d", i), dutAcc(0), 0);
      checkOutput($sformatf("release cnt %0d", i), dutCnt(0), 0);
    end
    applyStimulus(1'b0, 1'b0, -8);
    applyStimulus(1'b0, 1'b1, -8);
    checkOutput("post release acc", dutAcc(0), -8);
    checkOutput("post release cnt", dutCnt(0), 1);
    applyStimulus(1'b0, 1'b0, -8);

    $display("[TB] saturation");
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, satIn[i]);
      checkOutput($sformatf("sat acc %0d", i), dutAcc(1), satAcc[i]);
      checkOutput($sformatf("sat ovf %0d", i), dutOvf(1), satOvf[i]);
      checkOutput($sformatf("sat cnt %0d", i), dutCnt(1), i + 1);
      checkOutput($sformatf("sat done %0d", i), dutDone(1), (i == 3) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, satIn[i]);
      applyStimulus(1'b0, 1'b0, satIn[i]);
    end
    applyStimulus(1'b0, 1'b1, 7);
    checkOutput("sat restart acc", dutAcc(1), 7);
    checkOutput("sat restart ovf", dutOvf(1), 0);
    checkOutput("sat restart cnt", dutCnt(1), 1);
    applyStimulus(1'b0, 1'b0, 7);

    $display("[TB] wrap");
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 64);
    checkOutput("wrap acc 0", dutAcc(2), 64);
    checkOutput("wrap ovf 0", dutOvf(2), 0);
    applyStimulus(1'b0, 1'b0, 64);
    applyStimulus(1'b0, 1'b1, 64);
    checkOutput("wrap acc 1", dutAcc(2), -128);
    checkOutput("wrap ovf 1", dutOvf(2), 1);
    applyStimulus(1'b1, 1'b0, 64);
    checkOutput("wrap clear acc", dutAcc(2), 0);
    checkOutput("wrap clear cnt", dutCnt(2), 0);
    checkOutput("wrap clear ovf", dutOvf(2), 0);

    $display("[TB] reset mid-frame");
    sendProduct(50);
    sendProduct(-3);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("midreset acc", dutAcc(0), 0);
    checkOutput("midreset cnt", dutCnt(0), 0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      rst = (r < 2) ? 1'b0 : 1'b1;
      nextValid = mul_valid;
      if ($urandom_range(0, 2) == 0) nextValid = ~mul_valid;
      clear = (r >= 2 && r < 6);
      if (!mul_valid) mul_z = 8'($urandom);
      mul_valid = nextValid;
      tick();
    end
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
